// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 (x^5 + x^3 + 1) receiver-side checker with HUNT/LOCKED
// acquisition, saturating error counting and illegal zero-run detection.
module prbs5_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             zero_run
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] hist;        // hist[0] is the most recent accepted bit
    logic [2:0] fill;
    logic [3:0] match_cnt;
    logic [2:0] loss_cnt;
    logic [2:0] zero_cnt;

    logic predict;
    logic full;
    logic mismatch;
    logic counted;
    logic zero_hit;
    logic match_done;
    logic loss_done;

    always_comb begin
        predict    = hist[1] ^ hist[4];
        full       = (fill == 3'd5);
        mismatch   = din_valid && full && (din != predict);
        counted    = mismatch && (state == LOCKED);
        zero_hit   = din_valid && !din && (zero_cnt == 3'd4);
        match_done = (match_cnt == 4'(LOCK_CNT - 1));
        loss_done  = (loss_cnt == 3'(LOSS_CNT - 1));
    end

    // NOTE: every register here uses <= so all branches see pre-edge values;
    // where two assignments hit the same register, the later one wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            locked     <= 1'b0;
            hist       <= '0;
            fill       <= '0;
            match_cnt  <= '0;
            loss_cnt   <= '0;
            zero_cnt   <= '0;
            bit_err    <= 1'b0;
            zero_run   <= 1'b0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            bit_err  <= counted;
            zero_run <= zero_hit;

            if (clr_err) begin
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end else if (counted) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                err_sticky <= 1'b1;
            end

            if (din_valid) begin
                hist <= {hist[3:0], din};

                if (din)                    zero_cnt <= '0;
                else if (zero_cnt != 3'd5)  zero_cnt <= zero_cnt + 3'd1;

                if (!full) fill <= fill + 3'd1;

                // An impossible zero run means we are not looking at PRBS5 at all.
                if (zero_hit) begin
                    state     <= HUNT;
                    locked    <= 1'b0;
                    fill      <= '0;
                    match_cnt <= '0;
                    loss_cnt  <= '0;
                end else if (full) begin
                    case (state)
                        HUNT: begin
                            if (mismatch) begin
                                match_cnt <= '0;
                            end else if (match_done) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end
                        LOCKED: begin
                            if (!mismatch) begin
                                loss_cnt <= '0;
                            end else if (loss_done) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                fill      <= '0;
                                match_cnt <= '0;
                                loss_cnt  <= '0;
                            end else begin
                                loss_cnt <= loss_cnt + 3'd1;
                            end
                        end
                        default: begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: lock timing, error injection, loss/relock,
// zero-run detection, clear priority, saturation and asynchronous reset.
module tb_prbs5_checker;

    localparam logic [4:0] SEED = 5'b10111;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       clr_err;
    logic       locked;
    logic       bit_err;
    logic [3:0] err_cnt;
    logic       err_sticky;
    logic       zero_run;

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0] q;
    logic       last_bit;
    int         be_seen = 0;
    int         zr_seen = 0;
    int         be_base;
    int         zr_base;
    int         n;
    int         acc;
    int         cyc;

    always #5 clk = ~clk;

    prbs5_checker #(.ERR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .clr_err    (clr_err),
        .locked     (locked),
        .bit_err    (bit_err),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky),
        .zero_run   (zero_run)
    );

    // Pulses last a full cycle, so each is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (bit_err === 1'b1)  be_seen <= be_seen + 1;
        if (zero_run === 1'b1) zr_seen <= zr_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic v, input logic c);
        din       = b;
        din_valid = v;
        clr_err   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send(1'b0, 1'b0, 1'b0);
    endtask

    // Next bit of the reference LFSR stream, optionally inverted on the wire.
    task automatic clean(input logic flip, input logic c);
        logic b;
        b = q[0];
        q = {q[3] ^ q[0], q[4:1]};
        last_bit = b ^ flip;
        send(b ^ flip, 1'b1, c);
    endtask

    initial begin
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_bit_err", bit_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_zero_run", zero_run, 0);
        reset = 1'b0;

        // Clean stream: fill 5, then 8 matches -> locked after the 13th bit.
        q = SEED;
        for (int i = 1; i <= 13; i++) begin
            clean(1'b0, 1'b0);
            check("lock_point", locked, 32'(i == 13));
        end
        be_base = be_seen; zr_base = zr_seen;
        for (int i = 14; i <= 200; i++) clean(1'b0, 1'b0);
        idle();
        check("clean_err_cnt", err_cnt, 0);
        check("clean_locked", locked, 1);
        check("clean_bit_err_pulses", be_seen - be_base, 0);
        check("clean_zero_run_pulses", zr_seen - zr_base, 0);

        // Single inverted bit: mismatches at j, j+2, j+5.
        be_base = be_seen;
        clean(1'b1, 1'b0);
        check("flip1_bit_err", bit_err, 1);
        repeat (10) clean(1'b0, 1'b0);
        idle();
        check("flip1_pulses", be_seen - be_base, 3);
        check("flip1_err_cnt", err_cnt, 3);
        check("flip1_sticky", err_sticky, 1);
        check("flip1_locked", locked, 1);

        // Clear acts even without a valid bit.
        send(1'b0, 1'b0, 1'b1);
        check("clr_idle_err_cnt", err_cnt, 0);
        check("clr_idle_sticky", err_sticky, 0);
        check("clr_idle_locked", locked, 1);

        // Three inverted bits: mismatches j, j+1, j+3, j+4, j+5; lock lost at j+5.
        be_base = be_seen;
        for (int k = 0; k < 6; k++) begin
            clean(logic'(k < 3), 1'b0);
            check("burst_locked", locked, 32'(k < 5));
        end
        idle();
        check("burst_pulses", be_seen - be_base, 5);
        check("burst_err_cnt", err_cnt, 5);
        n = 0;
        do begin
            clean(1'b0, 1'b0);
            n++;
        end while (locked !== 1'b1 && n < 40);
        check("relock_bits", n, 13);
        check("relock_err_cnt", err_cnt, 5);

        // Clear coinciding with a counted mismatch: clear wins.
        clean(1'b1, 1'b1);
        check("clr_mis_err_cnt", err_cnt, 0);
        check("clr_mis_sticky", err_sticky, 0);
        check("clr_mis_bit_err", bit_err, 1);
        repeat (6) clean(1'b0, 1'b0);
        check("clr_mis_after_cnt", err_cnt, 2);
        check("clr_mis_after_sticky", err_sticky, 1);

        // Saturation: 7 isolated flips = 21 mismatches, held at 15.
        send(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 7; f++) begin
            clean(1'b1, 1'b0);
            repeat (7) clean(1'b0, 1'b0);
        end
        check("sat_err_cnt", err_cnt, 15);
        check("sat_sticky", err_sticky, 1);
        check("sat_locked", locked, 1);

        // Asynchronous reset mid-cycle, observed before any clock edge.
        idle();
        #3;
        reset = 1'b1;
        #1;
        check("async_locked", locked, 0);
        check("async_err_cnt", err_cnt, 0);
        check("async_sticky", err_sticky, 0);
        check("async_bit_err", bit_err, 0);
        check("async_zero_run", zero_run, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reacquire with a flip at bit 8 while hunting: mismatches 8, 10, 13
        // restart the match count, so lock lands on bit 21 and nothing is counted.
        q = SEED;
        be_base = be_seen;
        for (int i = 1; i <= 21; i++) begin
            clean(logic'(i == 8), 1'b0);
            check("hunt_lock_point", locked, 32'(i == 21));
        end
        idle();
        check("hunt_err_cnt", err_cnt, 0);
        check("hunt_sticky", err_sticky, 0);
        check("hunt_pulses", be_seen - be_base, 0);

        // Five forced zeros right after a 1 while locked.
        n = 0;
        while (last_bit !== 1'b1 && n < 10) begin
            clean(1'b0, 1'b0);
            n++;
        end
        zr_base = zr_seen;
        for (int k = 1; k <= 5; k++) begin
            send(1'b0, 1'b1, 1'b0);
            check("zero_run_pulse", zero_run, 32'(k == 5));
        end
        check("zero_run_locked", locked, 0);
        n = 0;
        do begin
            clean(1'b0, 1'b0);
            n++;
        end while (locked !== 1'b1 && n < 40);
        check("zero_relock_bits", n, 13);
        idle();
        check("zero_run_pulses", zr_seen - zr_base, 1);

        // Random din_valid gaps: lock still at the 13th accepted bit.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q = SEED; acc = 0; cyc = 0;
        while (locked !== 1'b1 && cyc < 200) begin
            if ($urandom_range(0, 1) == 1) begin
                clean(1'b0, 1'b0);
                acc++;
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            cyc++;
        end
        check("gap_lock_accepted", acc, 13);
        check("gap_locked", locked, 1);
        check("gap_err_cnt", err_cnt, 0);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
